// File: rtl/tl_exp_pkg.sv
// tl_exp_pkg: shared state enum, width constants and 7-segment patterns for the exponent engine
package tl_exp_pkg;
    localparam int OP_W  = 8;
    localparam int RES_W = 16;
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    // active-low segment patterns, g..a order, indexed by hex digit
    localparam logic [6:0] SEG_LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
endpackage

// File: rtl/tl_exp_fsmd_if.sv
// tl_exp_fsmd_if: start/operand inputs, result/done outputs and eight active-low hex displays
// master drives go_i/a_i/n_i; slave (the engine) drives output_reg, sig_done, seg0..seg7
interface tl_exp_fsmd_if;
    import tl_exp_pkg::*;
    logic             go_i;
    logic [OP_W-1:0]  a_i;
    logic [OP_W-1:0]  n_i;
    logic [RES_W-1:0] output_reg;
    logic             sig_done;
    logic [6:0]       seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
    modport master (output go_i, a_i, n_i,
                    input  output_reg, sig_done, seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7);
    modport slave  (input  go_i, a_i, n_i,
                    output output_reg, sig_done, seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7);
endinterface

// File: rtl/tl_exp_fsmd_hex_to_7seg.sv
// hex_to_7seg: one hex nibble to an active-low 7-segment pattern
// hex: 4-bit digit in; seg: bit0=a .. bit6=g, low = lit
module hex_to_7seg
    import tl_exp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    assign seg = SEG_LUT[hex];
endmodule

// File: rtl/tl_exp_fsmd.sv
// tl_exp_fsmd: a**n by repeated multiplication with go/done handshake and hex display
// clk/rst: clock, async active-high reset; bus: go_i/a_i/n_i in, output_reg/sig_done/seg0..seg7 out
module tl_exp_fsmd
    import tl_exp_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    tl_exp_fsmd_if.slave bus
);
    state_t           state;
    logic [OP_W-1:0]  a_r, n_r, cnt;
    logic [RES_W-1:0] acc;
    logic [3:0]       nib [8];
    logic [6:0]       seg [8];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            a_r            <= '0;
            n_r            <= '0;
            cnt            <= '0;
            acc            <= 16'd1;
            bus.output_reg <= '0;
            bus.sig_done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (bus.go_i) begin
                    a_r          <= bus.a_i;
                    n_r          <= bus.n_i;
                    cnt          <= bus.n_i;
                    acc          <= 16'd1;
                    bus.sig_done <= 1'b0;
                    state        <= MUL;
                end
                MUL: if (cnt != '0) begin
                    // product kept at 16 bits so overflow wraps each step
                    acc <= acc * {8'd0, a_r};
                    cnt <= cnt - 8'd1;
                end else begin
                    bus.output_reg <= acc;
                    bus.sig_done   <= 1'b1;
                    state          <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign nib[0] = bus.output_reg[3:0];
    assign nib[1] = bus.output_reg[7:4];
    assign nib[2] = bus.output_reg[11:8];
    assign nib[3] = bus.output_reg[15:12];
    assign nib[4] = n_r[3:0];
    assign nib[5] = n_r[7:4];
    assign nib[6] = a_r[3:0];
    assign nib[7] = a_r[7:4];
    for (genvar g = 0; g < 8; g++) begin : g_seg
        hex_to_7seg u_hex (.hex(nib[g]), .seg(seg[g]));
    end
    assign bus.seg0 = seg[0];
    assign bus.seg1 = seg[1];
    assign bus.seg2 = seg[2];
    assign bus.seg3 = seg[3];
    assign bus.seg4 = seg[4];
    assign bus.seg5 = seg[5];
    assign bus.seg6 = seg[6];
    assign bus.seg7 = seg[7];
endmodule

// File: tb/tb_tl_exp_fsmd.sv
// tb_tl_exp_fsmd: directed self-checking bench for the exponent engine
module tb_tl_exp_fsmd;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    localparam logic [6:0] S0 = 7'b1000000;
    tl_exp_fsmd_if bus ();
    tl_exp_fsmd dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero_segs(input string tag);
        check({tag, "_seg0"}, {25'd0, bus.seg0}, {25'd0, S0});
        check({tag, "_seg1"}, {25'd0, bus.seg1}, {25'd0, S0});
        check({tag, "_seg2"}, {25'd0, bus.seg2}, {25'd0, S0});
        check({tag, "_seg3"}, {25'd0, bus.seg3}, {25'd0, S0});
        check({tag, "_seg4"}, {25'd0, bus.seg4}, {25'd0, S0});
        check({tag, "_seg5"}, {25'd0, bus.seg5}, {25'd0, S0});
        check({tag, "_seg6"}, {25'd0, bus.seg6}, {25'd0, S0});
        check({tag, "_seg7"}, {25'd0, bus.seg7}, {25'd0, S0});
    endtask

    // one-cycle go, then scramble the operand inputs; waits for sig_done with a cycle budget
    task automatic run(input string tag, input logic [7:0] a, input logic [7:0] n, input logic [15:0] exp);
        int cyc = 0;
        @(negedge clk);
        bus.go_i = 1'b1;
        bus.a_i  = a;
        bus.n_i  = n;
        @(negedge clk);
        bus.go_i = 1'b0;
        bus.a_i  = ~a;
        bus.n_i  = 8'hff;
        check({tag, "_done_low"}, {31'd0, bus.sig_done}, 32'd0);
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (bus.sig_done) break;
        end
        check({tag, "_latency"}, cyc, n + 32'd1);
        check({tag, "_result"}, {16'd0, bus.output_reg}, {16'd0, exp});
    endtask

    initial begin
        bus.go_i = 1'b0;
        bus.a_i  = 8'd0;
        bus.n_i  = 8'd0;
        #12;
        check("rst_out", {16'd0, bus.output_reg}, 32'd0);
        check("rst_done", {31'd0, bus.sig_done}, 32'd0);
        check_all_zero_segs("rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_done", {31'd0, bus.sig_done}, 32'd0);
        check("idle_out", {16'd0, bus.output_reg}, 32'd0);

        run("p3_4", 8'd3, 8'd4, 16'd81);
        check("p3_4_seg0", {25'd0, bus.seg0}, {25'd0, 7'b1111001});
        check("p3_4_seg1", {25'd0, bus.seg1}, {25'd0, 7'b0010010});
        check("p3_4_seg2", {25'd0, bus.seg2}, {25'd0, S0});
        check("p3_4_seg3", {25'd0, bus.seg3}, {25'd0, S0});
        check("p3_4_seg4", {25'd0, bus.seg4}, {25'd0, 7'b0011001});
        check("p3_4_seg5", {25'd0, bus.seg5}, {25'd0, S0});
        check("p3_4_seg6", {25'd0, bus.seg6}, {25'd0, 7'b0110000});
        check("p3_4_seg7", {25'd0, bus.seg7}, {25'd0, S0});
        repeat (3) @(negedge clk);
        check("p3_4_hold_done", {31'd0, bus.sig_done}, 32'd1);
        check("p3_4_hold_out", {16'd0, bus.output_reg}, 32'd81);

        run("p2_10", 8'd2, 8'd10, 16'd1024);
        check("p2_10_seg2", {25'd0, bus.seg2}, {25'd0, 7'b0011001});
        check("p2_10_seg4", {25'd0, bus.seg4}, {25'd0, 7'b0001000});
        check("p2_10_seg6", {25'd0, bus.seg6}, {25'd0, 7'b0100100});
        run("p5_0", 8'd5, 8'd0, 16'd1);
        run("p0_0", 8'd0, 8'd0, 16'd1);
        run("p0_3", 8'd0, 8'd3, 16'd0);
        run("p2_17", 8'd2, 8'd17, 16'd0);
        run("p255_2", 8'd255, 8'd2, 16'hFE01);
        check("p255_2_seg3", {25'd0, bus.seg3}, {25'd0, 7'b0001110});
        check("p255_2_seg7", {25'd0, bus.seg7}, {25'd0, 7'b0001110});

        @(negedge clk);
        bus.go_i = 1'b1;
        bus.a_i  = 8'd3;
        bus.n_i  = 8'd8;
        @(negedge clk);
        bus.go_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out", {16'd0, bus.output_reg}, 32'd0);
        check("midrst_done", {31'd0, bus.sig_done}, 32'd0);
        check_all_zero_segs("midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("midrst_idle", {31'd0, bus.sig_done}, 32'd0);
        run("p3_8", 8'd3, 8'd8, 16'd6561);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tl_exp_fsmd.md
# tl_exp_fsmd

Integer exponent engine (FSMD) computing output_reg = a_i ** n_i by repeated multiplication, with a go/done handshake. The result and the latched operands are shown on eight active-low 7-segment hex digits. Top-level datapath/controller of the exponent demo; the LCD/board wrapper drives its inputs and displays.

## Interface
- No parameters. Widths are fixed: operands 8 bits, result 16 bits.
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- go_i  in  1  start request; sampled only in IDLE and DONE.
- a_i  in  8  base (unsigned).
- n_i  in  8  exponent (unsigned).
- output_reg  out  16  result register, a**n mod 2^16.
- sig_done  out  1  high while in DONE.
- seg0..seg7  out  7 each  active-low segments, bit0=a … bit6=g.

## Operation
- States: IDLE, MUL, DONE.
- IDLE:
  - On go_i=1: latch a_r<=a_i, n_r<=n_i, cnt<=n_i, acc<=16'd1; go to MUL.
  - Otherwise stay in IDLE.
- MUL:
  - If cnt!=0: acc<=(acc*a_r)[15:0], cnt<=cnt-1; stay in MUL.
  - If cnt==0: output_reg<=acc; go to DONE.
- DONE:
  - sig_done=1; output_reg holds its value.
  - go_i=1 acts exactly as in IDLE (relatch operands, go to MUL). sig_done drops when MUL is entered.
- Arithmetic:
  - Unsigned multiply; the product is truncated to 16 bits on every step, so overflow wraps mod 2^16.
  - n=0 gives 1, including 0**0=1. a=0 with n>0 gives 0.
- a_i/n_i changes after the latch have no effect until the next start.
- output_reg is written only on the MUL→DONE transition, so intermediate products never appear on it.
- Displays (combinational from registers):
  - seg0..seg3: output_reg hex nibbles, [3:0] through [15:12].
  - seg4, seg5: n_r low and high nibbles.
  - seg6, seg7: a_r low and high nibbles.
- Hex patterns, g..a order, active low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110

## Timing
- Reset values:
  - State IDLE.
  - output_reg=0, sig_done=0, acc=1, cnt=0, a_r=0, n_r=0.
  - All segs display "0" (1000000).
- Latency: go_i sampled at edge E0; multiplies occur at E1..En; DONE is entered at E(n+1). sig_done is high from just after E(n+1), i.e. n+1 cycles after the start edge.
- A one-cycle go_i pulse is sufficient. If go_i is held high, DONE lasts one cycle and then the computation restarts.
- rst asserted mid-computation aborts immediately to the reset values; there is no partial result.
- sig_done and the segs are glitch-free decodes of registered state and registers.

## Structure
- Shared package tl_exp_pkg: state enum (IDLE/MUL/DONE), width constants (OP_W=8, RES_W=16), 16-entry segment pattern constant.
- One sub-module, hex_to_7seg (4-bit in, 7-bit active-low out), instantiated eight times.
- Controller and datapath stay in the top module.

## Test plan
- Reset: rst=1 → output_reg=0, sig_done=0, every seg=1000000. Release rst with go_i=0 → stays idle for 10 cycles.
- Basic: a=3, n=4, one-cycle go.
  - sig_done high 5 cycles after the start edge; output_reg=81.
  - seg0=1111001, seg1=0010010, seg2=seg3=1000000.
  - seg4=0011001, seg6=0110000, seg5=seg7=1000000.
- Edges:
  - a=5, n=0 → output_reg=1 after 1 cycle.
  - a=0, n=0 → 1.
  - a=0, n=3 → 0.
- Overflow: a=2, n=17 → output_reg=0. a=255, n=2 → 65025 (0xFE01).
- Restart from DONE: after 3**4, go with a=2, n=10 → sig_done drops next cycle, then output_reg=1024. Operand changes mid-computation are ignored.
- Mid-run reset: assert rst during MUL of a=3, n=8 → immediate reset values. A fresh start then yields 6561.
